// File: rtl/term_writer.sv
// Serial-terminal character engine: turns an accepted byte stream into VRAM cell writes
// and cursor moves. Optional horizontal-tab support is enabled by defining TERM_TAB_EN.
module term_writer #(
  parameter int COLS     = 60,
  parameter int ROWS     = 17,
  parameter int TAB_STOP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_data,
  output logic        o_vram_ce,
  output logic [5:0]  o_cursor_x,
  output logic [4:0]  o_cursor_y
);

  typedef enum logic [1:0] {IDLE, CLRLINE, CLRALL} state_t;

  localparam logic [5:0] LastCol = 6'(COLS - 1);
  localparam logic [4:0] LastRow = 5'(ROWS - 1);
  localparam logic [7:0] Space   = 8'h20;

  state_t      r_state;
  logic [5:0]  r_x;
  logic [4:0]  r_y;
  logic [5:0]  r_sweepX;
  logic [4:0]  r_sweepY;
  logic        r_vramCe;
  logic [10:0] r_vramAddr;
  logic [7:0]  r_vramData;

  logic       w_printable;
  logic [4:0] w_nextRow;

  assign w_printable = (i_data >= 8'h20) && (i_data != 8'h7F);
  // Bottom row wraps back to the top: VRAM is write-only, so there is no scroll.
  assign w_nextRow   = (r_y == LastRow) ? 5'd0 : r_y + 5'd1;

`ifdef TERM_TAB_EN
  logic [6:0] w_tabRaw;
  logic [5:0] w_tabX;

  assign w_tabRaw = {1'b0, r_x | 6'(TAB_STOP - 1)} + 7'd1;
  assign w_tabX   = (w_tabRaw > {1'b0, LastCol}) ? LastCol : w_tabRaw[5:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= CLRALL;
      r_x        <= '0;
      r_y        <= '0;
      r_sweepX   <= '0;
      r_sweepY   <= '0;
      r_vramCe   <= 1'b0;
      r_vramAddr <= '0;
      r_vramData <= '0;
    end else begin
      r_vramCe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            if (w_printable) begin
              r_vramCe   <= 1'b1;
              r_vramAddr <= {r_y, r_x};
              r_vramData <= i_data;
              if (r_x == LastCol) begin
                r_x     <= '0;
                r_y     <= w_nextRow;
                r_state <= CLRLINE;
              end else begin
                r_x <= r_x + 6'd1;
              end
            end else begin
              case (i_data)
                8'h0D: r_x <= '0;
                8'h0A: begin
                  r_y     <= w_nextRow;
                  r_state <= CLRLINE;
                end
                8'h08: begin
                  if (r_x != 6'd0) begin
                    r_x        <= r_x - 6'd1;
                    r_vramCe   <= 1'b1;
                    r_vramAddr <= {r_y, r_x - 6'd1};
                    r_vramData <= Space;
                  end
                end
                8'h0C: begin
                  r_x     <= '0;
                  r_y     <= '0;
                  r_state <= CLRALL;
                end
`ifdef TERM_TAB_EN
                8'h09: r_x <= w_tabX;
`endif
                default: ;
              endcase
            end
          end
        end

        // Sweep counters always rest at zero in IDLE, so both sweeps start at column 0.
        CLRLINE: begin
          r_vramCe   <= 1'b1;
          r_vramAddr <= {r_y, r_sweepX};
          r_vramData <= Space;
          if (r_sweepX == LastCol) begin
            r_sweepX <= '0;
            r_state  <= IDLE;
          end else begin
            r_sweepX <= r_sweepX + 6'd1;
          end
        end

        CLRALL: begin
          r_vramCe   <= 1'b1;
          r_vramAddr <= {r_sweepY, r_sweepX};
          r_vramData <= Space;
          if (r_sweepX == LastCol) begin
            r_sweepX <= '0;
            if (r_sweepY == LastRow) begin
              r_sweepY <= '0;
              r_state  <= IDLE;
            end else begin
              r_sweepY <= r_sweepY + 5'd1;
            end
          end else begin
            r_sweepX <= r_sweepX + 6'd1;
          end
        end

        default: r_state <= CLRALL;
      endcase
    end
  end

  assign o_ready     = (r_state == IDLE);
  assign o_vram_ce   = r_vramCe;
  assign o_vram_addr = r_vramAddr;
  assign o_vram_data = r_vramData;
  assign o_cursor_x  = r_x;
  assign o_cursor_y  = r_y;

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: reset sweep, printing, wrap + line clear, backspace/CR,
// tab handling (TERM_TAB_EN aware) and reset in the middle of a screen clear.
module tb_term_writer;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [10:0] o_vram_addr;
  logic [7:0]  o_vram_data;
  logic        o_vram_ce;
  logic [5:0]  o_cursor_x;
  logic [4:0]  o_cursor_y;

  int checkCount = 0;
  int errorCount = 0;

  term_writer dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_vram_addr(o_vram_addr),
    .o_vram_data(o_vram_data),
    .o_vram_ce  (o_vram_ce),
    .o_cursor_x (o_cursor_x),
    .o_cursor_y (o_cursor_y)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %0d want %0d", tag, actual, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!o_ready && n < 200) begin
      tick();
      n++;
    end
    if (!o_ready) checkOutput("readyTimeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    waitReady();
    i_data  = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_data  = 8'h00;
  endtask

  function automatic int cellAddr(input int row, input int col);
    return row * 64 + col;
  endfunction

  // Follows a full-screen clear until o_ready returns, checking every write in row-major order.
  task automatic sweepCheck(input string tag);
    int idx = 0;
    int n = 0;
    while (n < 1200) begin
      tick();
      n++;
      if (o_vram_ce) begin
        checkOutput({tag, "Addr"}, int'(o_vram_addr), cellAddr(idx / 60, idx % 60));
        checkOutput({tag, "Data"}, int'(o_vram_data), 32'h20);
        idx++;
      end
      if (o_ready) break;
    end
    checkOutput({tag, "ReadyRise"}, int'(o_ready), 1);
    tick();
    if (o_vram_ce) idx++;
    checkOutput({tag, "Count"}, idx, 1020);
    checkOutput({tag, "CurX"}, int'(o_cursor_x), 0);
    checkOutput({tag, "CurY"}, int'(o_cursor_y), 0);
  endtask

  initial begin
    int tabX;
    int fill;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    tick();
    tick();

    checkOutput("rstCe", int'(o_vram_ce), 0);
    checkOutput("rstAddr", int'(o_vram_addr), 0);
    checkOutput("rstData", int'(o_vram_data), 0);
    checkOutput("rstReady", int'(o_ready), 0);
    checkOutput("rstCurX", int'(o_cursor_x), 0);
    checkOutput("rstCurY", int'(o_cursor_y), 0);

    i_rst = 1'b0;
    sweepCheck("boot");

    // Back-to-back printable bytes.
    waitReady();
    i_data = 8'h41; i_valid = 1'b1;
    tick();
    checkOutput("aCe", int'(o_vram_ce), 1);
    checkOutput("aAddr", int'(o_vram_addr), cellAddr(0, 0));
    checkOutput("aData", int'(o_vram_data), 32'h41);
    checkOutput("aReady", int'(o_ready), 1);
    i_data = 8'h42;
    tick();
    i_valid = 1'b0;
    checkOutput("bCe", int'(o_vram_ce), 1);
    checkOutput("bAddr", int'(o_vram_addr), cellAddr(0, 1));
    checkOutput("bData", int'(o_vram_data), 32'h42);
    checkOutput("abCurX", int'(o_cursor_x), 2);
    checkOutput("abCurY", int'(o_cursor_y), 0);
    tick();
    checkOutput("abIdleCe", int'(o_vram_ce), 0);

    // Walk to the bottom-right cell, then wrap.
    applyStimulus(8'h0D);
    checkOutput("crCe", int'(o_vram_ce), 0);
    checkOutput("crCurX", int'(o_cursor_x), 0);
    for (int i = 0; i < 16; i++) applyStimulus(8'h0A);
    for (int i = 0; i < 59; i++) applyStimulus(8'h61);
    checkOutput("preZCurX", int'(o_cursor_x), 59);
    checkOutput("preZCurY", int'(o_cursor_y), 16);
    applyStimulus(8'h5A);
    checkOutput("zCe", int'(o_vram_ce), 1);
    checkOutput("zAddr", int'(o_vram_addr), cellAddr(16, 59));
    checkOutput("zData", int'(o_vram_data), 32'h5A);
    checkOutput("zCurX", int'(o_cursor_x), 0);
    checkOutput("zCurY", int'(o_cursor_y), 0);
    checkOutput("zReady", int'(o_ready), 0);
    for (int i = 1; i <= 60; i++) begin
      tick();
      checkOutput("lineCe", int'(o_vram_ce), 1);
      checkOutput("lineAddr", int'(o_vram_addr), cellAddr(0, i - 1));
      checkOutput("lineData", int'(o_vram_data), 32'h20);
      checkOutput("lineReady", int'(o_ready), (i == 60) ? 1 : 0);
    end
    tick();
    checkOutput("lineDoneCe", int'(o_vram_ce), 0);

    // LF keeps the column; BS and CR.
    for (int i = 0; i < 5; i++) applyStimulus(8'h62);
    for (int i = 0; i < 3; i++) applyStimulus(8'h0A);
    waitReady();
    checkOutput("lfCurX", int'(o_cursor_x), 5);
    checkOutput("lfCurY", int'(o_cursor_y), 3);
    applyStimulus(8'h08);
    checkOutput("bsCe", int'(o_vram_ce), 1);
    checkOutput("bsAddr", int'(o_vram_addr), cellAddr(3, 4));
    checkOutput("bsData", int'(o_vram_data), 32'h20);
    checkOutput("bsCurX", int'(o_cursor_x), 4);
    applyStimulus(8'h0D);
    checkOutput("cr2Ce", int'(o_vram_ce), 0);
    checkOutput("cr2CurX", int'(o_cursor_x), 0);
    checkOutput("cr2CurY", int'(o_cursor_y), 3);
    applyStimulus(8'h08);
    checkOutput("bs0Ce", int'(o_vram_ce), 0);
    checkOutput("bs0CurX", int'(o_cursor_x), 0);
    applyStimulus(8'h07);
    checkOutput("belCe", int'(o_vram_ce), 0);
    checkOutput("belReady", int'(o_ready), 1);
    applyStimulus(8'h7F);
    checkOutput("delCe", int'(o_vram_ce), 0);
    checkOutput("delCurX", int'(o_cursor_x), 0);

    // Horizontal tab.
    for (int i = 0; i < 3; i++) applyStimulus(8'h63);
    applyStimulus(8'h09);
`ifdef TERM_TAB_EN
    tabX = 8;
`else
    tabX = 3;
`endif
    checkOutput("ht3Ce", int'(o_vram_ce), 0);
    checkOutput("ht3CurX", int'(o_cursor_x), tabX);
    fill = 58 - tabX;
    for (int i = 0; i < fill; i++) applyStimulus(8'h64);
    checkOutput("pre58CurX", int'(o_cursor_x), 58);
    applyStimulus(8'h09);
`ifdef TERM_TAB_EN
    tabX = 59;
`else
    tabX = 58;
`endif
    checkOutput("ht58Ce", int'(o_vram_ce), 0);
    checkOutput("ht58CurX", int'(o_cursor_x), tabX);
    checkOutput("ht58Ready", int'(o_ready), 1);

    // Form feed, then reset half way through the clear.
    applyStimulus(8'h0C);
    checkOutput("ffCe", int'(o_vram_ce), 0);
    checkOutput("ffCurX", int'(o_cursor_x), 0);
    checkOutput("ffCurY", int'(o_cursor_y), 0);
    checkOutput("ffReady", int'(o_ready), 0);
    for (int i = 0; i < 510; i++) tick();
    checkOutput("midCe", int'(o_vram_ce), 1);
    checkOutput("midAddr", int'(o_vram_addr), cellAddr(8, 29));
    i_rst = 1'b1;
    tick();
    checkOutput("abortCe", int'(o_vram_ce), 0);
    checkOutput("abortAddr", int'(o_vram_addr), 0);
    checkOutput("abortReady", int'(o_ready), 0);
    i_rst = 1'b0;
    sweepCheck("restart");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
